// File: rtl/reg_writeback_if.sv
// Bundle of the execute-result handshake, register-file write port and forwarding lookup.
interface reg_writeback_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              RegWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] fwd_reg;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_reg, in_data, stall, fwd_reg,
        output in_ready, RegWrite, writeReg, writeData, fwd_hit, fwd_data, count
    );

    modport master (
        output in_valid, in_reg, in_data, stall, fwd_reg,
        input  in_ready, RegWrite, writeReg, writeData, fwd_hit, fwd_data, count
    );
endinterface

// File: rtl/reg_writeback.sv
// Writeback FIFO feeding the register-file write port, with youngest-wins
// combinational forwarding over queued entries and the output stage.
module reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_writeback_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              ready_s, push_s, store_s, pop_s;
    logic              fwd_hit_s, match_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic [PTR_W-1:0]  idx_s;

    // Register 0 completes the handshake but is never stored.
    assign ready_s = (count_q < DEPTH_C);
    assign push_s  = bus.in_valid && ready_s;
    assign store_s = push_s && (bus.in_reg != {ADDR_W{1'b0}});
    assign pop_s   = (count_q != {CNT_W{1'b0}}) && !bus.stall;

    // Next-state for pointers, occupancy and the write-port output stage.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (store_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            regwrite_d = 1'b1;
            wreg_d     = reg_mem_q[rd_ptr_q];
            wdata_d    = data_mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d   = rd_ptr_q;
            regwrite_d = 1'b0;
        end
        case ({store_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Entry storage; only non-zero destinations are written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_q[i]  <= {ADDR_W{1'b0}};
                data_mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (store_s) begin
            reg_mem_q[wr_ptr_q]  <= bus.in_reg;
            data_mem_q[wr_ptr_q] <= bus.in_data;
        end else begin
            reg_mem_q[wr_ptr_q]  <= reg_mem_q[wr_ptr_q];
            data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            regwrite_q <= 1'b0;
            wreg_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Forwarding: output stage is oldest, then FIFO entries oldest to newest, so later matches win.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        idx_s      = rd_ptr_q;
        match_s    = 1'b0;
        if (regwrite_q && (wreg_q == bus.fwd_reg)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = wdata_q;
        end else begin
            fwd_hit_s  = 1'b0;
            fwd_data_s = {DATA_W{1'b0}};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx_s   = rd_ptr_q + PTR_W'(i);
            match_s = (CNT_W'(i) < count_q) && (reg_mem_q[idx_s] == bus.fwd_reg);
            if (match_s) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_mem_q[idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
        if (bus.fwd_reg == {ADDR_W{1'b0}}) begin
            fwd_hit_s  = 1'b0;
            fwd_data_s = {DATA_W{1'b0}};
        end else begin
            fwd_hit_s  = fwd_hit_s;
            fwd_data_s = fwd_data_s;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.RegWrite  = regwrite_q;
    assign bus.writeReg  = wreg_q;
    assign bus.writeData = wdata_q;
    assign bus.fwd_hit   = fwd_hit_s;
    assign bus.fwd_data  = fwd_data_s;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: inputs change on the falling edge, outputs are checked half a cycle after each rising edge.
module tb_reg_writeback;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [ADDR_W-1:0] log_reg  [$];
    logic [DATA_W-1:0] log_data [$];
    logic [ADDR_W-1:0] exp_reg  [$];
    logic [DATA_W-1:0] exp_data [$];
    logic [ADDR_W-1:0] rnd_reg;
    logic [DATA_W-1:0] rnd_data;

    reg_writeback_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every write the register file would commit.
    always begin
        @(posedge clk);
        #2;
        if (rst_n && bus.RegWrite) begin
            log_reg.push_back(bus.writeReg);
            log_data.push_back(bus.writeData);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.in_valid = v;
        bus.in_reg   = r;
        bus.in_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 5'd0, 32'h0);
        bus.stall   = 1'b0;
        bus.fwd_reg = 5'd0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_regwrite", bus.RegWrite, 1'b0);
        check_val("rst_writereg", bus.writeReg, 5'd0);
        check_val("rst_writedata", bus.writeData, 32'h0);
        check_val("rst_count", bus.count, 3'd0);
        check_val("rst_ready", bus.in_ready, 1'b1);
        check_val("rst_fwd_hit", bus.fwd_hit, 1'b0);
        check_val("rst_fwd_data", bus.fwd_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write r3 = 0xAA
        log_reg.delete(); log_data.delete();
        drive(1'b1, 5'd3, 32'h0000_00AA);
        bus.fwd_reg = 5'd3;
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0);
        check_val("sw1_count", bus.count, 3'd1);
        check_val("sw1_regwrite", bus.RegWrite, 1'b0);
        check_val("sw1_fwd_hit", bus.fwd_hit, 1'b1);
        check_val("sw1_fwd_data", bus.fwd_data, 32'hAA);
        @(negedge clk);
        check_val("sw2_regwrite", bus.RegWrite, 1'b1);
        check_val("sw2_writereg", bus.writeReg, 5'd3);
        check_val("sw2_writedata", bus.writeData, 32'hAA);
        check_val("sw2_fwd_hit", bus.fwd_hit, 1'b1);
        check_val("sw2_fwd_data", bus.fwd_data, 32'hAA);
        check_val("sw2_count", bus.count, 3'd0);
        @(negedge clk);
        check_val("sw3_regwrite", bus.RegWrite, 1'b0);
        check_val("sw3_fwd_hit", bus.fwd_hit, 1'b0);
        check_val("sw3_fwd_data", bus.fwd_data, 32'h0);
        check_val("sw_log_size", log_reg.size(), 1);

        // Register-0 push is consumed and dropped
        drive(1'b1, 5'd0, 32'hDEAD);
        bus.fwd_reg = 5'd0;
        #1;
        check_val("r0_ready", bus.in_ready, 1'b1);
        check_val("r0_fwd_hit_pre", bus.fwd_hit, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0);
        check_val("r0_count", bus.count, 3'd0);
        check_val("r0_ready_post", bus.in_ready, 1'b1);
        check_val("r0_fwd_hit", bus.fwd_hit, 1'b0);
        @(negedge clk);
        check_val("r0_regwrite", bus.RegWrite, 1'b0);
        @(negedge clk);
        check_val("r0_log_size", log_reg.size(), 1);

        // Stall fills the buffer; r5 is held until the first pop frees a slot
        log_reg.delete(); log_data.delete();
        bus.stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, ADDR_W'(i), DATA_W'(i));
            if (i == 5) begin
                #1;
                check_val("full_ready_pre", bus.in_ready, 1'b0);
            end
            @(negedge clk);
            if (i == 4) begin
                check_val("full_count", bus.count, 3'd4);
                check_val("full_ready", bus.in_ready, 1'b0);
            end
        end
        check_val("full_count_held", bus.count, 3'd4);
        check_val("full_regwrite", bus.RegWrite, 1'b0);
        bus.stall = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            check_val("bp_regwrite", bus.RegWrite, 1'b1);
            check_val("bp_writereg", bus.writeReg, ADDR_W'(j));
            check_val("bp_writedata", bus.writeData, DATA_W'(j));
            if (j == 1) begin
                check_val("bp_count1", bus.count, 3'd3);
                check_val("bp_ready1", bus.in_ready, 1'b1);
            end
            if (j == 2) begin
                check_val("bp_count2", bus.count, 3'd3);
                drive(1'b0, 5'd0, 32'h0);
            end
        end
        @(negedge clk);
        check_val("bp_idle_regwrite", bus.RegWrite, 1'b0);
        check_val("bp_idle_count", bus.count, 3'd0);
        check_val("bp_log_size", log_reg.size(), 5);

        // Forwarding priority: two writes to r7
        log_reg.delete(); log_data.delete();
        bus.stall = 1'b1;
        drive(1'b1, 5'd7, 32'h11);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h22);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0);
        bus.fwd_reg = 5'd7;
        #1;
        check_val("fp_count", bus.count, 3'd2);
        check_val("fp_hit", bus.fwd_hit, 1'b1);
        check_val("fp_data", bus.fwd_data, 32'h22);
        bus.stall = 1'b0;
        @(negedge clk);
        check_val("fp_pop1_wdata", bus.writeData, 32'h11);
        check_val("fp_pop1_fwd", bus.fwd_data, 32'h22);
        @(negedge clk);
        check_val("fp_pop2_wdata", bus.writeData, 32'h22);
        check_val("fp_pop2_hit", bus.fwd_hit, 1'b1);
        check_val("fp_pop2_fwd", bus.fwd_data, 32'h22);
        @(negedge clk);
        check_val("fp_end_hit", bus.fwd_hit, 1'b0);
        check_val("fp_log_size", log_data.size(), 2);
        if (log_data.size() == 2) begin
            check_val("fp_log0", log_data[0], 32'h11);
            check_val("fp_log1", log_data[1], 32'h22);
        end

        // Output stage drops on the first stalled edge and is not re-sent
        log_reg.delete(); log_data.delete();
        bus.stall = 1'b1;
        drive(1'b1, 5'd9, 32'h99);
        @(negedge clk);
        drive(1'b1, 5'd10, 32'hA0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0);
        bus.stall = 1'b0;
        @(negedge clk);
        check_val("st_pop_regwrite", bus.RegWrite, 1'b1);
        check_val("st_pop_writereg", bus.writeReg, 5'd9);
        bus.stall = 1'b1;
        @(negedge clk);
        check_val("st_drop_regwrite", bus.RegWrite, 1'b0);
        check_val("st_drop_count", bus.count, 3'd1);
        @(negedge clk);
        check_val("st_hold_regwrite", bus.RegWrite, 1'b0);
        bus.stall = 1'b0;
        @(negedge clk);
        check_val("st_resume_writereg", bus.writeReg, 5'd10);
        check_val("st_resume_writedata", bus.writeData, 32'hA0);
        @(negedge clk);
        check_val("st_log_size", log_reg.size(), 2);

        // Wrap-around with simultaneous push and pop
        log_reg.delete(); log_data.delete();
        exp_reg.delete(); exp_data.delete();
        bus.stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rnd_reg  = ADDR_W'($urandom_range(31, 1));
            rnd_data = $urandom;
            exp_reg.push_back(rnd_reg);
            exp_data.push_back(rnd_data);
            drive(1'b1, rnd_reg, rnd_data);
            if (i == 2) bus.stall = 1'b0;
            @(negedge clk);
            if (i >= 2) check_val("wr_count", bus.count, 3'd2);
        end
        drive(1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (bus.count == 3'd0) break;
            @(negedge clk);
        end
        check_val("wr_drained", bus.count, 3'd0);
        check_val("wr_log_size", log_reg.size(), 12);
        if (log_reg.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                check_val("wr_log_reg", log_reg[i], exp_reg[i]);
                check_val("wr_log_data", log_data[i], exp_data[i]);
            end
        end

        // Reset mid-stream with 3 queued entries and a write in flight
        bus.stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, ADDR_W'(i), 32'h100 + DATA_W'(i));
            @(negedge clk);
        end
        drive(1'b0, 5'd0, 32'h0);
        bus.stall = 1'b0;
        bus.fwd_reg = 5'd2;
        @(negedge clk);
        bus.stall = 1'b1;
        check_val("mr_pre_regwrite", bus.RegWrite, 1'b1);
        check_val("mr_pre_count", bus.count, 3'd3);
        rst_n = 1'b0;
        #1;
        check_val("mr_regwrite", bus.RegWrite, 1'b0);
        check_val("mr_count", bus.count, 3'd0);
        check_val("mr_ready", bus.in_ready, 1'b1);
        check_val("mr_fwd_hit", bus.fwd_hit, 1'b0);
        log_reg.delete(); log_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mr_no_write", log_reg.size(), 0);
        check_val("mr_post_count", bus.count, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
